// File: rtl/serial_word_loader.sv
// rtl/serial_word_loader.sv - framed 5-bit serial receiver that loads a downstream register
module serial_word_loader #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clock,
    input  logic       clear_n,
    input  logic       serial_in,
    output logic [4:0] word_out,
    output logic       load,
    output logic       frame_error,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [4:0]       shift_q, shift_d;
    logic [4:0]       word_q, word_d;
    logic             load_q, load_d;
    logic             ferr_q, ferr_d;
    logic             busy_q, busy_d;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            word_q    <= '0;
            load_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            word_q    <= word_d;
            load_q    <= load_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    // The counter restarts at every sample point, so each sample lands one
    // full bit period after the previous one, starting from mid start bit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        word_d    = word_q;
        load_d    = 1'b0;
        ferr_d    = ferr_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!serial_in) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!serial_in) begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    for (int i = 0; i < 5; i++) begin
                        if (bit_idx_q == 3'(i)) begin
                            shift_d[i] = serial_in;
                        end
                    end
                    if (bit_idx_q == 3'd4) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (serial_in) begin
                        word_d  = shift_q;
                        load_d  = 1'b1;
                        ferr_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                cnt_d = '0;
                if (serial_in) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign word_out    = word_q;
    assign load        = load_q;
    assign frame_error = ferr_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_serial_word_loader.sv
// tb/tb_serial_word_loader.sv - scoreboard bench for serial_word_loader
module tb_serial_word_loader;

    localparam int C = 4;

    logic       clock;
    logic       clear_n;
    logic       serial_in;
    logic [4:0] word_out;
    logic       load;
    logic       frame_error;
    logic       busy;

    serial_word_loader #(.CLKS_PER_BIT(C)) dut (
        .clock      (clock),
        .clear_n    (clear_n),
        .serial_in  (serial_in),
        .word_out   (word_out),
        .load       (load),
        .frame_error(frame_error),
        .busy       (busy)
    );

    typedef struct {
        logic [4:0] word;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every load pulse must match the oldest outstanding good frame.
    always @(negedge clock) begin
        if (load === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_load", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("load_word", int'(word_out), int'(e.word));
                check("load_cycle", cyc, e.cyc);
                check("load_ferr", int'(frame_error), 0);
            end
        end
    end

    // Called on a negedge; the following posedge is E0.
    task automatic send_frame(input logic [4:0] w, input logic stop, input bit good);
        logic [6:0] bits;
        exp_t e;
        bits = {stop, w, 1'b0};
        if (good) begin
            e.word = w;
            e.cyc  = cyc + 1 + C / 2 + 6 * C;
            sb_q.push_back(e);
        end
        for (int i = 0; i < 7; i++) begin
            serial_in = bits[i];
            repeat (C) @(negedge clock);
        end
    endtask

    initial begin
        clear_n   = 1'b0;
        serial_in = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_word", int'(word_out), 0);
        check("rst_load", int'(load), 0);
        check("rst_ferr", int'(frame_error), 0);
        check("rst_busy", int'(busy), 0);
        clear_n = 1'b1;
        repeat (2) @(negedge clock);

        send_frame(5'd3, 1'b1, 1'b1);
        serial_in = 1'b1;
        @(negedge clock);
        check("f3_word", int'(word_out), 3);
        check("f3_ferr", int'(frame_error), 0);
        check("f3_busy", int'(busy), 0);

        send_frame(5'd10, 1'b1, 1'b1);
        send_frame(5'd21, 1'b1, 1'b1);
        serial_in = 1'b1;
        repeat (2) @(negedge clock);
        check("b2b_word", int'(word_out), 21);

        send_frame(5'd31, 1'b0, 1'b0);
        serial_in = 1'b0;
        repeat (10) @(negedge clock);
        check("bad_ferr", int'(frame_error), 1);
        check("bad_word", int'(word_out), 21);
        check("bad_busy_low_line", int'(busy), 1);
        serial_in = 1'b1;
        @(negedge clock);
        check("bad_busy_released", int'(busy), 0);
        repeat (2) @(negedge clock);

        serial_in = 1'b0;
        @(negedge clock);
        check("glitch_busy_e0", int'(busy), 1);
        serial_in = 1'b1;
        @(negedge clock);
        check("glitch_busy_e1", int'(busy), 1);
        @(negedge clock);
        check("glitch_busy_e2", int'(busy), 0);
        check("glitch_ferr", int'(frame_error), 1);
        check("glitch_word", int'(word_out), 21);
        repeat (2) @(negedge clock);

        send_frame(5'd12, 1'b1, 1'b1);
        serial_in = 1'b1;
        @(negedge clock);
        check("f12_ferr", int'(frame_error), 0);
        check("f12_word", int'(word_out), 12);

        serial_in = 1'b0;
        repeat (C) @(negedge clock);
        serial_in = 1'b1;
        repeat (C + 2) @(negedge clock);
        check("mid_busy", int'(busy), 1);
        #2 clear_n = 1'b0;
        #1;
        check("async_word", int'(word_out), 0);
        check("async_load", int'(load), 0);
        check("async_ferr", int'(frame_error), 0);
        check("async_busy", int'(busy), 0);
        @(negedge clock);
        repeat (2) @(negedge clock);
        check("held_busy", int'(busy), 0);
        clear_n = 1'b1;
        send_frame(5'd5, 1'b1, 1'b1);
        serial_in = 1'b1;
        @(negedge clock);
        check("f5_word", int'(word_out), 5);

        repeat (40) @(negedge clock);
        check("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_word_loader.md
SERIAL_WORD_LOADER -- requirements
Module: serial_word_loader

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 4, clock cycles per serial bit period; SHALL be even and >= 2.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 clear_n  input  1  reset; one clock, asynchronous assertion, active-low.
REQ-004 serial_in  input  1  serial line, idle high, synchronous to clock; no internal synchronizer.
REQ-005 word_out  output  5  last correctly framed word; drives register_in of the downstream 5-bit register.
REQ-006 load  output  1  one-cycle strobe; drives load of the downstream 5-bit register.
REQ-007 frame_error  output  1  high when the most recent frame had a bad stop bit.
REQ-008 busy  output  1  high whenever state is not IDLE.

Function
REQ-009 Frame format SHALL be: 1 start bit (0), 5 data bits LSB first, 1 stop bit (1), each CLKS_PER_BIT cycles long.
REQ-010 States SHALL be IDLE, START, DATA, STOP, WAIT_HIGH; all outputs registered.
REQ-011 IDLE: on the edge where serial_in = 0, go to START and clear the cycle counter; call this edge E0.
REQ-012 START: at edge E0 + CLKS_PER_BIT/2, sample serial_in; 0 -> DATA, bit index = 0; 1 -> IDLE (glitch, no outputs change).
REQ-013 DATA: data bit k (k = 0..4) SHALL be sampled at edge E0 + CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT into shift-register bit k.
REQ-014 DATA: after bit 4 is sampled, go to STOP.
REQ-015 STOP: sample serial_in at edge E0 + CLKS_PER_BIT/2 + 6*CLKS_PER_BIT.
REQ-016 Stop = 1: at that same edge, word_out <= assembled word, load <= 1, frame_error <= 0; next state IDLE.
REQ-017 Stop = 0: at that same edge, frame_error <= 1; word_out unchanged; load stays 0; next state WAIT_HIGH.
REQ-018 WAIT_HIGH: remain until serial_in = 1 is sampled, then go to IDLE; no start detection in this state.
REQ-019 load SHALL be high for exactly one clock per good frame and never high otherwise.
REQ-020 frame_error SHALL hold its value until the next stop-bit sample.
REQ-021 A start bit detected on the edge immediately after returning to IDLE SHALL be accepted; back-to-back frames incur no dead cycles beyond the stop bit's remaining half period.
REQ-022 serial_in activity during START/DATA/STOP SHALL only be sampled at the defined mid-bit edges.
REQ-023 Cycle counter width SHALL be ceil(log2(CLKS_PER_BIT)) bits minimum; bit index 3 bits.

Reset
REQ-024 clear_n = 0 SHALL immediately force: state IDLE, word_out = 5'd0, load = 0, frame_error = 0, busy = 0, counters and shift register = 0.
REQ-025 Reset mid-frame SHALL abort the frame with no load pulse; after release, the block waits in IDLE for a new start bit.
REQ-026 First start detection SHALL be possible on the first rising edge after clear_n deasserts.

Verification (CLKS_PER_BIT = 4)
REQ-027 Good frame 5'd3 (line 0,1,1,0,0,0,1) -> load high one cycle at edge E0+26, word_out = 3, frame_error = 0, busy low after.
REQ-028 Frame 5'd10 followed immediately by 5'd21 -> two single-cycle load pulses, word_out 10 then 21, no missed bits.
REQ-029 Frame 5'd31 with stop bit 0, line held low 10 more cycles -> no load, word_out keeps previous value, frame_error = 1, busy stays high until line returns high.
REQ-030 Start glitch: serial_in low for 1 cycle only -> return to IDLE at E0+2, no load, word_out and frame_error unchanged.
REQ-031 clear_n pulsed low mid-DATA of frame 5'd7 -> all outputs 0 asynchronously, no load; next good frame 5'd5 loads 5.
REQ-032 After frame_error, good frame 5'd12 -> frame_error returns to 0 at the load edge, word_out = 12.
